// File: rtl/rd_drain_pkg.sv
// Shared definitions for the read-FIFO to UART drain block.
//
// Contents:
//   - drain_state_e : drain FSM state encoding
//   - WordW / ByteW : FIFO word width and UART byte width
//   - DataNumMax    : largest legal DATA_NUM (words per drain)
//   - CntW / LevelW : word-counter width and FIFO fill-level width

package rd_drain_pkg;

    localparam int unsigned WordW      = 16;
    localparam int unsigned ByteW      = 8;
    localparam int unsigned DataNumMax = 512;
    localparam int unsigned CntW       = 9;
    localparam int unsigned LevelW     = 10;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StPop,
        StLat,
        StByte0,
        StByte1,
        StDone
    } drain_state_e;

endpackage

// File: rtl/rd_word_split.sv
// Holds one 16-bit word and presents it to the UART as two bytes with a
// valid/ready hold.
//
// Configuration macro: RD_DRAIN_LSB_FIRST_EN
//   undefined (default) : first byte = word[15:8], second byte = word[7:0]
//   defined             : first byte = word[7:0],  second byte = word[15:8]
//
// Ports:
//   sys_clk   in   clock
//   sys_rst   in   synchronous active-high reset
//   word      in   word to capture when load is high
//   load      in   capture word and start presenting its first byte
//   tx_ready  in   UART accepts tx_data this cycle (when tx_valid)
//   tx_data   out  selected byte, 0 while tx_valid is low
//   tx_valid  out  tx_data valid, held until accepted
//   last_byte out  the byte currently presented is the second of the word

module rd_word_split
    import rd_drain_pkg::*;
(
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WordW-1:0] word,
    input  logic             load,
    input  logic             tx_ready,
    output logic [ByteW-1:0] tx_data,
    output logic             tx_valid,
    output logic             last_byte
);

    logic [WordW-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             sel_q, sel_d;
    logic             hs;
    logic [ByteW-1:0] first_byte;
    logic [ByteW-1:0] second_byte;

`ifdef RD_DRAIN_LSB_FIRST_EN
    assign first_byte  = word_q[ByteW-1:0];
    assign second_byte = word_q[WordW-1:ByteW];
`else
    assign first_byte  = word_q[WordW-1:ByteW];
    assign second_byte = word_q[ByteW-1:0];
`endif

    assign hs = valid_q & tx_ready;

    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        if (load) begin
            word_d  = word;
            valid_d = 1'b1;
            sel_d   = 1'b0;
        end else if (hs) begin
            if (sel_q) begin
                valid_d = 1'b0;
                sel_d   = 1'b0;
            end else begin
                sel_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
        end
    end

    // Drive zero when idle so the byte lane is quiet between words.
    assign tx_data   = valid_q ? (sel_q ? second_byte : first_byte) : '0;
    assign tx_valid  = valid_q;
    assign last_byte = sel_q;

endmodule

// File: rtl/rd_fifo_uart_drain.sv
// Drains DATA_NUM 16-bit words from the SDRAM read FIFO (normal, non
// show-ahead mode) and sends each as two bytes to a UART transmitter.
//
// Configuration macro: RD_DRAIN_LSB_FIRST_EN (byte order, see rd_word_split).
//
// Parameters:
//   DATA_NUM         words drained per start, legal 1..512
//
// Ports:
//   sys_clk          in   single clock
//   sys_rst          in   synchronous active-high reset
//   start            in   one-cycle pulse, ignored while busy
//   rd_fifo_num      in   read-FIFO fill level
//   rd_fifo_rd_data  in   read-FIFO word, valid the cycle after rd_fifo_rd_req
//   rd_fifo_rd_req   out  read-FIFO pop strobe
//   read_valid       out  enables SDRAM-to-FIFO refill during a drain
//   tx_data          out  byte to UART
//   tx_valid         out  tx_data valid
//   tx_ready         in   UART accepts the byte
//   busy             out  drain in progress
//   done             out  one-cycle pulse after the last byte is accepted

module rd_fifo_uart_drain
    import rd_drain_pkg::*;
#(
    parameter int unsigned DATA_NUM = 10
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [LevelW-1:0] rd_fifo_num,
    input  logic [WordW-1:0]  rd_fifo_rd_data,
    output logic              rd_fifo_rd_req,
    output logic              read_valid,
    output logic [ByteW-1:0]  tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [LevelW-1:0] NeedLevel = LevelW'(DATA_NUM);
    localparam logic [CntW-1:0]   LastIdx   = CntW'(DATA_NUM - 1);

    drain_state_e    state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            active_q, active_d;
    logic            load;
    logic            hs;
    logic            last_byte;

    rd_word_split u_split (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .word      (rd_fifo_rd_data),
        .load      (load),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .last_byte (last_byte)
    );

    assign hs = tx_valid & tx_ready;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        active_d       = active_q;
        rd_fifo_rd_req = 1'b0;
        load           = 1'b0;
        done           = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StWait;
                    cnt_d    = '0;
                    active_d = 1'b1;
                end
            end
            StWait: begin
                if (rd_fifo_num >= NeedLevel) begin
                    state_d = StPop;
                end
            end
            StPop: begin
                // Never pop an empty FIFO; wait here until a word appears.
                if (rd_fifo_num != '0) begin
                    rd_fifo_rd_req = 1'b1;
                    state_d        = StLat;
                end
            end
            StLat: begin
                // FIFO output is valid this cycle, one after the pop.
                load    = 1'b1;
                state_d = StByte0;
            end
            StByte0: begin
                if (hs && !last_byte) begin
                    state_d = StByte1;
                end
            end
            StByte1: begin
                if (hs && last_byte) begin
                    if (cnt_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StPop;
                    end
                end
            end
            StDone: begin
                done     = 1'b1;
                active_d = 1'b0;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign busy       = active_q;
    assign read_valid = active_q;

endmodule
